// File: rtl/ongorucu_pkg.sv
// Shared constants, counter encodings and B-type immediate decoding
// for the gshare branch predictor.
package ongorucu_pkg;

  localparam logic [6:0] DALLANMA_OPCODE = 7'b1100011;

  typedef enum logic [1:0] {
    GUCLU_ATLAMAZ = 2'b00,
    ZAYIF_ATLAMAZ = 2'b01,
    ZAYIF_ATLAR   = 2'b10,
    GUCLU_ATLAR   = 2'b11
  } sayac_e;

  // B-type offset: 13-bit even immediate, sign-extended to 32 bits
  function automatic logic [31:0] imm_cikar(input logic [31:0] b);
    return {{19{b[31]}}, b[31], b[7], b[30:25], b[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/ongorucu_gshare_doygun_sayac.sv
// One 2-bit saturating direction counter with a parametrised reset value.
module doygun_sayac
  import ongorucu_pkg::*;
#(
  parameter logic [1:0] BASLANGIC = ZAYIF_ATLAMAZ
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic       i_atladi,
  output logic [1:0] o_deger
);

  logic [1:0] r_deger;

  // Count toward the resolved direction, holding at either end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_deger <= BASLANGIC;
    end else if (i_en) begin
      if (i_atladi) begin
        if (r_deger != GUCLU_ATLAR) begin
          r_deger <= r_deger + 2'd1;
        end
      end else begin
        if (r_deger != GUCLU_ATLAMAZ) begin
          r_deger <= r_deger - 2'd1;
        end
      end
    end
  end

  assign o_deger = r_deger;

endmodule

// File: rtl/ongorucu_gshare.sv
// Fetch-stage direction predictor: bimodal or gshare-indexed table of
// 2-bit counters, non-speculative global history and saturating stats.
module ongorucu_gshare
  import ongorucu_pkg::*;
#(
  parameter int         IDX_BIT         = 6,
  parameter int         GECMIS_BIT      = 4,
  parameter int         MOD             = 1,
  parameter int         PS_LSB          = 2,
  parameter logic [1:0] SAYAC_BASLANGIC = 2'b01
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [31:0]           ps_i,
  input  logic [31:0]           buyruk_i,
  input  logic                  guncelle_gecerli_i,
  input  logic                  guncelle_atladi_i,
  input  logic [31:0]           guncelle_ps_i,
  output logic [31:0]           atlanan_ps_o,
  output logic                  atlanan_gecerli_o,
  output logic [GECMIS_BIT-1:0] gecmis_o,
  output logic [31:0]           dogru_sayisi_o,
  output logic [31:0]           yanlis_sayisi_o
);

  localparam int DERINLIK = 1 << IDX_BIT;

  logic [GECMIS_BIT-1:0] r_ghr;
  logic [31:0]           r_dogru;
  logic [31:0]           r_yanlis;

  logic [IDX_BIT-1:0]    w_gecmis_katki;
  logic [IDX_BIT-1:0]    w_tahmin_idx;
  logic [IDX_BIT-1:0]    w_gunc_idx;
  logic [1:0]            w_pht [DERINLIK];
  logic                  w_dallanma;
  logic                  w_eski_tahmin;
  logic                  w_unused_bitler;

  assign w_gecmis_katki = (MOD != 0) ? IDX_BIT'(r_ghr) : {IDX_BIT{1'b0}};
  assign w_tahmin_idx   = ps_i[PS_LSB +: IDX_BIT] ^ w_gecmis_katki;
  assign w_gunc_idx     = guncelle_ps_i[PS_LSB +: IDX_BIT] ^ w_gecmis_katki;

  for (genvar g = 0; g < DERINLIK; g++) begin : g_pht
    doygun_sayac #(
      .BASLANGIC (SAYAC_BASLANGIC)
    ) u_sayac (
      .i_clk    (clk_i),
      .i_rst    (rst_i),
      .i_en     (guncelle_gecerli_i && (w_gunc_idx == IDX_BIT'(g))),
      .i_atladi (guncelle_atladi_i),
      .o_deger  (w_pht[g])
    );
  end

  assign w_dallanma    = (buyruk_i[6:0] == DALLANMA_OPCODE);
  assign w_eski_tahmin = w_pht[w_gunc_idx][1];

  // Index bits outside the hashed slice and the immediate's don't-care field
  assign w_unused_bitler = ^{ps_i, guncelle_ps_i, buyruk_i};

  assign atlanan_gecerli_o = w_dallanma && w_pht[w_tahmin_idx][1];
  assign atlanan_ps_o      = ps_i + (w_dallanma ? imm_cikar(buyruk_i) : 32'd4);

  // History shifts in the resolved direction; stats judge the pre-update entry
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ghr    <= {GECMIS_BIT{1'b0}};
      r_dogru  <= 32'd0;
      r_yanlis <= 32'd0;
    end else if (guncelle_gecerli_i) begin
      r_ghr <= GECMIS_BIT'({r_ghr, guncelle_atladi_i});
      if (w_eski_tahmin == guncelle_atladi_i) begin
        if (r_dogru != 32'hFFFF_FFFF) begin
          r_dogru <= r_dogru + 32'd1;
        end
      end else begin
        if (r_yanlis != 32'hFFFF_FFFF) begin
          r_yanlis <= r_yanlis + 32'd1;
        end
      end
    end
  end

  assign gecmis_o        = r_ghr;
  assign dogru_sayisi_o  = r_dogru;
  assign yanlis_sayisi_o = r_yanlis;

endmodule
